// File: rtl/cache_ctrl_if.sv
// Request-side and main-memory-side buses of the direct-mapped cache controller.
// The master view belongs to the requester/memory environment, the slave view to the controller.
interface cache_ctrl_if #(
  parameter int ADDR_BIT  = 32,
  parameter int WORD_SIZE = 32
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_BIT-1:0]  cpu_addr;
  logic [WORD_SIZE-1:0] cpu_wdata;
  logic                 cpu_ready;
  logic [WORD_SIZE-1:0] cpu_rdata;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BIT-1:0]  mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with a word-serial
// handshaked main-memory port (victim write-back burst, refill burst, then retry as hit).
module cache_ctrl #(
  parameter int NUM_BLOCK      = 1024,
  parameter int WORD_PER_BLOCK = 16,
  parameter int WORD_SIZE      = 32,
  parameter int ADDR_BIT       = 32,
  parameter int INDEX_BIT      = $clog2(NUM_BLOCK),
  parameter int OFFSET_BIT     = $clog2(WORD_PER_BLOCK),
  parameter int TAG_BIT        = ADDR_BIT - INDEX_BIT - OFFSET_BIT
) (
  input logic         clk,
  input logic         rst_n,
  cache_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_REFILL    = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [1:0] FLAG_INV   = 2'b00;
  localparam logic [1:0] FLAG_CLEAN = 2'b10;
  localparam logic [1:0] FLAG_DIRTY = 2'b11;

  state_t                  state_r, state_nxt_s;
  logic [OFFSET_BIT-1:0]   cnt_r, cnt_nxt_s;
  logic                    req_we_r;
  logic [ADDR_BIT-1:0]     req_addr_r;
  logic [WORD_SIZE-1:0]    req_wdata_r;

  logic [1:0]              flag_r [NUM_BLOCK];
  logic [TAG_BIT-1:0]      tag_r  [NUM_BLOCK];
  logic [WORD_SIZE-1:0]    data_r [NUM_BLOCK*WORD_PER_BLOCK];

  logic                    cpu_ready_r, cpu_ready_s;
  logic [WORD_SIZE-1:0]    cpu_rdata_r;
  logic                    mem_req_r, mem_req_s;
  logic                    mem_we_r, mem_we_s;
  logic [ADDR_BIT-1:0]     mem_addr_r, mem_addr_s;
  logic [WORD_SIZE-1:0]    mem_wdata_r, mem_wdata_s;

  logic [TAG_BIT-1:0]      req_tag_s;
  logic [INDEX_BIT-1:0]    req_idx_s;
  logic [OFFSET_BIT-1:0]   req_off_s;
  logic [1:0]              line_flag_s;
  logic [TAG_BIT-1:0]      line_tag_s;
  logic                    hit_s;
  logic                    beat_done_s;
  logic                    last_beat_s;

  assign req_tag_s   = req_addr_r[ADDR_BIT-1 -: TAG_BIT];
  assign req_idx_s   = req_addr_r[OFFSET_BIT +: INDEX_BIT];
  assign req_off_s   = req_addr_r[OFFSET_BIT-1:0];
  assign line_flag_s = flag_r[req_idx_s];
  assign line_tag_s  = tag_r[req_idx_s];
  assign hit_s       = line_flag_s[1] && (line_tag_s == req_tag_s);
  // An ack only counts while a beat is actually being requested.
  assign beat_done_s = mem_req_r && bus.mem_ack;
  assign last_beat_s = &cnt_r;

  assign bus.cpu_ready = cpu_ready_r;
  assign bus.cpu_rdata = cpu_rdata_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.cpu_req) state_nxt_s = ST_LOOKUP;
        else             state_nxt_s = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (hit_s)                          state_nxt_s = ST_DONE;
        else if (line_flag_s == FLAG_DIRTY) state_nxt_s = ST_WRITEBACK;
        else                                state_nxt_s = ST_REFILL;
      end
      ST_WRITEBACK: begin
        if (beat_done_s && last_beat_s) state_nxt_s = ST_REFILL;
        else                            state_nxt_s = ST_WRITEBACK;
      end
      ST_REFILL: begin
        if (beat_done_s && last_beat_s) state_nxt_s = ST_LOOKUP;
        else                            state_nxt_s = ST_REFILL;
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the state being entered so the
  // memory beat is already presented in the first cycle of a burst.
  always_comb begin
    cnt_nxt_s   = '0;
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    cpu_ready_s = (state_nxt_s == ST_DONE);
    if ((state_r == ST_WRITEBACK) || (state_r == ST_REFILL)) begin
      if (beat_done_s) cnt_nxt_s = cnt_r + OFFSET_BIT'(1'b1);
      else             cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = '0;
    end
    case (state_nxt_s)
      ST_WRITEBACK: begin
        mem_req_s   = 1'b1;
        mem_we_s    = 1'b1;
        mem_addr_s  = {line_tag_s, req_idx_s, cnt_nxt_s};
        mem_wdata_s = data_r[{req_idx_s, cnt_nxt_s}];
      end
      ST_REFILL: begin
        mem_req_s   = 1'b1;
        mem_we_s    = 1'b0;
        mem_addr_s  = {req_tag_s, req_idx_s, cnt_nxt_s};
        mem_wdata_s = '0;
      end
      default: begin
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
      end
    endcase
  end

  // Control registers, line flags and registered outputs; reset discards dirty lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= '0;
      req_we_r    <= 1'b0;
      req_addr_r  <= '0;
      req_wdata_r <= '0;
      cpu_ready_r <= 1'b0;
      cpu_rdata_r <= '0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      for (int i = 0; i < NUM_BLOCK; i++) begin
        flag_r[i] <= FLAG_INV;
      end
    end else begin
      cnt_r       <= cnt_nxt_s;
      cpu_ready_r <= cpu_ready_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      if ((state_r == ST_IDLE) && bus.cpu_req) begin
        req_we_r    <= bus.cpu_we;
        req_addr_r  <= bus.cpu_addr;
        req_wdata_r <= bus.cpu_wdata;
      end
      if ((state_r == ST_LOOKUP) && hit_s) begin
        if (req_we_r) flag_r[req_idx_s] <= FLAG_DIRTY;
        else          cpu_rdata_r       <= data_r[{req_idx_s, req_off_s}];
      end
      if ((state_r == ST_WRITEBACK) && beat_done_s && last_beat_s) begin
        flag_r[req_idx_s] <= FLAG_CLEAN;
      end
      if ((state_r == ST_REFILL) && beat_done_s && last_beat_s) begin
        flag_r[req_idx_s] <= FLAG_CLEAN;
      end
    end
  end

  // Tag and data storage (no reset: contents are qualified by the flags).
  always_ff @(posedge clk) begin
    if (rst_n && (state_r == ST_LOOKUP) && hit_s && req_we_r) begin
      data_r[{req_idx_s, req_off_s}] <= req_wdata_r;
    end
    if (rst_n && (state_r == ST_REFILL) && beat_done_s) begin
      data_r[{req_idx_s, cnt_r}] <= bus.mem_rdata;
      if (last_beat_s) tag_r[req_idx_s] <= req_tag_s;
    end
  end

endmodule
